// File: rtl/serial_mux_adder_pkg.sv
// Shared types and elaboration helpers for the serial mux-cell adder.
package serial_mux_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to hold the values 0..steps, i.e. clog2(steps+1).
  function automatic int unsigned step_cnt_width(input int unsigned steps);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((steps >> (i - 1)) != 0) w = i;
    end
    return w;
  endfunction

  // Legal configuration: WIDTH >= 2, 1 <= BITS_PER_CYCLE <= WIDTH, and it divides WIDTH.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned bpc);
    return (width >= 2) && (bpc >= 1) && (bpc <= width) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/serial_mux_adder_mux_fa_cell.sv
// 1-bit full adder built only from 2:1 multiplexer primitives.

module mux2_cell (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module mux_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic nb, p, nci;

  // Inverters realised as muxes selecting between constants.
  mux2_cell u_inv_b  (.sel(b),  .d0(1'b1), .d1(1'b0), .y(nb));
  mux2_cell u_inv_ci (.sel(ci), .d0(1'b1), .d1(1'b0), .y(nci));
  // Propagate p = a ^ b.
  mux2_cell u_prop   (.sel(a),  .d0(b),    .d1(nb),   .y(p));
  // Sum = p ^ ci.
  mux2_cell u_sum    (.sel(p),  .d0(ci),   .d1(nci),  .y(s));
  // Carry: generate (a==b -> a) or propagate ci.
  mux2_cell u_carry  (.sel(p),  .d0(a),    .d1(ci),   .y(co));
endmodule

// File: rtl/serial_mux_adder.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB first,
// through a carry register, with valid/ready handshakes on both sides.
module serial_mux_adder
  import serial_mux_adder_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = step_cnt_width(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  if (!cfg_ok(WIDTH, BITS_PER_CYCLE)) begin : g_cfg_check
    $error("serial_mux_adder: BITS_PER_CYCLE must divide WIDTH");
  end

  state_e               state_q, state_d;
  logic [CW-1:0]        step_q, step_d, step_inc;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, acc_q, acc_d, acc_next;
  logic                 carry_q, carry_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic                 cout_q, cout_d, ovf_q, ovf_d;
  logic                 inc_c;

  logic [BITS_PER_CYCLE:0]   c_chain;
  logic [BITS_PER_CYCLE-1:0] s_chain;

  assign c_chain[0] = carry_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_chain
    mux_fa_cell u_fa (
      .a  (a_q[i]),
      .b  (b_q[i]),
      .ci (c_chain[i]),
      .s  (s_chain[i]),
      .co (c_chain[i+1])
    );
  end

  // New sum bits enter at the MSB end; after N steps the result is aligned.
  assign acc_next = WIDTH'({s_chain, acc_q} >> BITS_PER_CYCLE);

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Next-state and datapath updates; step counter increments via a half-adder ripple.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    step_inc = '0;
    inc_c    = 1'b1;
    for (int unsigned i = 0; i < CW; i++) begin
      step_inc[i] = step_q[i] ^ inc_c;
      inc_c       = step_q[i] & inc_c;
    end
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          acc_d   = '0;
          step_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> BITS_PER_CYCLE;
        b_d     = b_q >> BITS_PER_CYCLE;
        carry_d = c_chain[BITS_PER_CYCLE];
        acc_d   = acc_next;
        step_d  = step_inc;
        if (step_q == LAST_STEP) begin
          sum_d   = acc_next;
          cout_d  = c_chain[BITS_PER_CYCLE];
          ovf_d   = c_chain[BITS_PER_CYCLE-1] ^ c_chain[BITS_PER_CYCLE];
          step_d  = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_mux_adder.sv
// Bench for serial_mux_adder: bit-serial (BPC=1) and nibble (BPC=4) instances.
module tb_serial_mux_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv1, ir1, cin1, sub1, ov1, or1, cout1, ovf1;
  logic [7:0] a1, b1, sum1;
  logic       iv2, ir2, cin2, sub2, ov2, or2, cout2, ovf2;
  logic [7:0] a2, b2, sum2;

  serial_mux_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(sum1),
    .cout(cout1), .ovf(ovf1)
  );

  serial_mux_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .cin(cin2), .sub(sub2), .out_valid(ov2), .out_ready(or2), .sum(sum2),
    .cout(cout2), .ovf(ovf2)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [9:0]  q1[$];
  logic [9:0]  q2[$];

  // Reference: {sum, cout, ovf} computed with ordinary integer addition.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic s);
    logic [7:0] bb;
    logic       ci;
    logic [8:0] full;
    logic [7:0] low;
    bb   = s ? ~b : b;
    ci   = s ? 1'b1 : c;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, ci};
    low  = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + {7'd0, ci};
    return {full[7:0], full[8], low[7] ^ full[8]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on the BPC=1 instance, holding DONE for 'hold' cycles.
  task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic s, input int unsigned hold);
    int unsigned cyc;
    logic [9:0]  exp;
    logic [9:0]  held;
    cyc = 0;
    while (!ir1 && cyc < 40) begin tick(); cyc++; end
    check("op1_in_ready_idle", ir1, 1);
    a1 = a; b1 = b; cin1 = c; sub1 = s; iv1 = 1'b1;
    q1.push_back(model(a, b, c, s));
    tick();
    iv1 = 1'b0; a1 = ~a; b1 = ~b; cin1 = ~c; sub1 = ~s;
    check("op1_in_ready_busy", ir1, 0);
    cyc = 0;
    while (!ov1 && cyc < 40) begin tick(); cyc++; end
    check("op1_latency", cyc, 8);
    held = {sum1, cout1, ovf1};
    for (int unsigned i = 0; i < hold; i++) begin
      iv1 = 1'b1;
      tick();
      check("hold_out_valid", ov1, 1);
      check("hold_in_ready", ir1, 0);
      check("hold_result", {sum1, cout1, ovf1}, held);
    end
    iv1 = 1'b0;
    check("op1_sb_size", q1.size(), 1);
    exp = (q1.size() != 0) ? q1.pop_front() : 'x;
    check("op1_result", {sum1, cout1, ovf1}, exp);
    or1 = 1'b1;
    tick();
    or1 = 1'b0;
    check("op1_released", ov1, 0);
    check("op1_idle_keeps_result", {sum1, cout1, ovf1}, exp);
  endtask

  // One operation on the BPC=4 instance; out_ready stays high.
  task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic s, input string tag);
    int unsigned cyc;
    logic [9:0]  exp;
    cyc = 0;
    while (!ir2 && cyc < 40) begin tick(); cyc++; end
    a2 = a; b2 = b; cin2 = c; sub2 = s; iv2 = 1'b1;
    q2.push_back(model(a, b, c, s));
    tick();
    iv2 = 1'b0; a2 = $urandom; b2 = $urandom;
    cyc = 0;
    while (!ov2 && cyc < 40) begin tick(); cyc++; end
    check({tag, "_latency"}, cyc, 2);
    exp = (q2.size() != 0) ? q2.pop_front() : 'x;
    check({tag, "_result"}, {sum2, cout2, ovf2}, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    iv1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; or1 = 0;
    iv2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0; or2 = 1;
    tick(); tick();
    rst_n = 1'b1;
    check("reset_in_ready", ir1, 1);
    check("reset_out_valid", ov1, 0);
    check("reset_outputs", {sum1, cout1, ovf1}, 10'd0);
    check("reset2_outputs", {ir2, ov2, sum2, cout2, ovf2}, 12'h800);

    // Carry-out wraps, signed overflow with carry-in, subtraction cases.
    op1(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    op1(8'h7F, 8'h01, 1'b1, 1'b0, 0);
    op1(8'h05, 8'h07, 1'b0, 1'b1, 0);
    op1(8'h80, 8'h01, 1'b1, 1'b1, 0);

    // Back-pressure with in_valid pulses that must not start a new op.
    op1(8'h3C, 8'h42, 1'b1, 1'b0, 5);
    for (int unsigned i = 0; i < 10; i++) tick();
    check("no_phantom_op", ov1, 0);
    check("no_phantom_sb", q1.size(), 0);

    // Reset at the third RUN step discards the in-flight op.
    op1(8'h80, 8'h01, 1'b0, 1'b1, 0);
    a1 = 8'h11; b1 = 8'h22; cin1 = 0; sub1 = 0; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrun_reset_in_ready", ir1, 1);
    check("midrun_reset_out_valid", ov1, 0);
    check("midrun_reset_outputs", {sum1, cout1, ovf1}, 10'd0);
    for (int unsigned i = 0; i < 10; i++) tick();
    check("midrun_reset_no_result", ov1, 0);
    op1(8'h10, 8'h20, 1'b0, 1'b0, 0);

    // Nibble-wide instance: directed, then random.
    op2(8'hA5, 8'h5B, 1'b0, 1'b0, "bpc4_a5_5b");
    op2(8'h80, 8'h01, 1'b0, 1'b1, "bpc4_sub");
    for (int unsigned i = 0; i < 1000; i++) begin
      op2(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "bpc4_rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
